prbs26_checker: RTL
===================

Name: prbs26_checker

Overview:
Serial PRBS checker that sits directly downstream of the team's 26-bit LFSR pattern generator. It consumes that generator's serial output, self-synchronises to the sequence and then counts bit errors. The pattern's recurrence is b[n+1] = b[n] ^ b[n-6] ^ b[n-7] ^ b[n-25], which is the x^26+x^8+x^7+x+1 sequence observed at stage 26. Typical use is link BIST: generator, then channel, then this block.

Parameters:
LOCK_COUNT, 32, consecutive correct predictions required in VERIFY before lock is declared (1..255)
WINDOW, 64, length in valid bits of the loss-of-lock observation window while LOCKED (2..65535)
LOSS_THRESH, 8, errors within one WINDOW that drop lock (1..WINDOW)
ERR_W, 16, width of the error counter

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  reset, synchronous, active-low
bit_vld  input  1  bit_in is valid this cycle; cycles without it are ignored entirely
bit_in  input  1  received serial PRBS bit
clr_cnt  input  1  synchronous clear of err_cnt
locked  output  1  high while in LOCKED state
err_pulse  output  1  one-cycle strobe per mismatching bit while LOCKED
err_cnt  output  ERR_W  saturating count of errors detected while LOCKED

Behaviour:
- Reset (rst_n=0 at posedge) has priority over everything, including mid-operation.
  - State goes to FILL. History h[25:0]=0, fill/match/window/window-error counters=0.
  - Outputs: locked=0, err_pulse=0, err_cnt=0.
- History: h[0] is the newest bit, h[k]=b[n-k]. Prediction p = h[0]^h[6]^h[7]^h[25] (combinational from current h).
- Only cycles with bit_vld=1 advance state, counters or history. err_pulse is 0 on any cycle following a bit_vld=0 cycle.
- FILL:
  - Each valid bit is shifted into h (received bit).
  - After the 26th valid bit, go to VERIFY; match counter=0.
- VERIFY:
  - Each valid bit: compare bit_in with p, then shift bit_in into h.
  - Match: match counter +1. At LOCK_COUNT, go to LOCKED on that same edge (locked=1 from the next cycle). Window counters are cleared.
  - Mismatch: go to FILL, fill counter=0. The bit just shifted in counts as fill bit 1.
  - If h==0 when a bit is evaluated, it is treated as a mismatch, so an all-zero stream never locks.
  - err_pulse and err_cnt are not affected in FILL or VERIFY.
- LOCKED:
  - Each valid bit: shift p (not bit_in) into h, so the local generator free-runs and every channel error is counted exactly once.
  - bit_in != p:
    - err_pulse=1 for exactly the next cycle.
    - err_cnt +1, saturating at 2^ERR_W-1.
    - Window error counter +1.
  - Window counter +1 per valid bit. On reaching WINDOW, the window counter and window error counter reset to 0.
  - If the window error counter reaches LOSS_THRESH (including on the error just sampled): go to FILL, locked=0 next cycle, history/fill counter cleared. The bit just sampled is discarded.
- clr_cnt:
  - err_cnt=0 on that edge.
  - If an error is detected on the same edge, err_cnt=1 (clear then count).
  - It does not affect state, locked or the window counters.
- Latency: bit sampled at edge N; err_pulse, err_cnt and locked all reflect it after edge N (registered outputs, no combinational path from inputs to outputs).

Test Plan:
1. Generator loaded with 26'h0000001, bit_vld=1 continuously, clean stream → locked rises after the edge sampling valid bit 58 (26+32); err_cnt=0.
2. Locked, invert one bit → err_pulse high for exactly 1 cycle, err_cnt=1, locked stays 1. The next 100 clean bits produce no further pulses.
3. Locked, invert 8 bits within 40 consecutive valid bits → 8 pulses, err_cnt=8, locked falls after the 8th. A clean stream relocks 58 valid bits later.
4. Locked, 7 errors in one window, then 7 more in the next window (WINDOW=64) → locked stays 1, err_cnt=14. Saturation check with ERR_W=4: errors stop incrementing at 15.
5. bit_in held 0 for 500 valid bits from reset → locked never asserts, err_pulse never asserts. Repeat with bit_vld toggling 1-of-3 cycles on a clean stream → lock after 58 valid bits (≈174 clocks).
6. Locked with err_cnt=5: clr_cnt coincident with an error → err_cnt=1. Then rst_n=0 for one edge → locked=0, err_cnt=0, err_pulse=0 next cycle, and the block relocks from FILL.

Source files
------------

// File: rtl/prbs26_checker.sv
// Serial PRBS checker for the x^26+x^8+x^7+x+1 pattern (b[n+1] = b[n]^b[n-6]^b[n-7]^b[n-25]).
// Self-synchronises by filling a local history from the line, verifies a run of correct
// predictions, then free-runs the local generator and counts channel bit errors.
module prbs26_checker #(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {StFill, StVerify, StLocked} state_e;

  localparam logic [4:0]  FillLast = 5'd25;
  localparam logic [7:0]  LockLast = 8'(LOCK_COUNT - 1);
  localparam logic [15:0] WinLast  = 16'(WINDOW - 1);
  localparam logic [15:0] LossLast = 16'(LOSS_THRESH - 1);

  state_e           state_q, state_d;
  logic [25:0]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [15:0]      win_q, win_d;
  logic [15:0]      win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;

  logic pred;
  logic mismatch;
  logic err_det;

  // hist_q[0] is the newest bit, hist_q[k] = b[n-k]
  assign pred     = hist_q[0] ^ hist_q[6] ^ hist_q[7] ^ hist_q[25];
  assign mismatch = (bit_in != pred);

  // Next-state: sync sequencing, history update, window bookkeeping and error counting
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_det     = 1'b0;

    if (bit_vld) begin
      case (state_q)
        StFill: begin
          hist_d = {hist_q[24:0], bit_in};
          fill_d = fill_q + 5'd1;
          if (fill_q == FillLast) begin
            state_d = StVerify;
            match_d = '0;
          end
        end
        StVerify: begin
          hist_d = {hist_q[24:0], bit_in};
          // An all-zero history predicts zeros forever, so it must never count as a match
          if (mismatch || (hist_q == '0)) begin
            state_d = StFill;
            fill_d  = 5'd1;
          end else begin
            match_d = match_q + 8'd1;
            if (match_q == LockLast) begin
              state_d   = StLocked;
              win_d     = '0;
              win_err_d = '0;
            end
          end
        end
        StLocked: begin
          // Free-run on the prediction so each channel error is seen exactly once
          hist_d  = {hist_q[24:0], pred};
          err_det = mismatch;
          if (mismatch && (win_err_q == LossLast)) begin
            state_d   = StFill;
            hist_d    = '0;
            fill_d    = '0;
            win_d     = '0;
            win_err_d = '0;
          end else if (win_q == WinLast) begin
            win_d     = '0;
            win_err_d = '0;
          end else begin
            win_d     = win_q + 16'd1;
            win_err_d = win_err_q + {15'd0, mismatch};
          end
        end
        default: state_d = StFill;
      endcase
    end

    // Clear wins over the old value but an error on the same edge still counts
    if (clr_cnt) begin
      err_cnt_d = err_det ? ERR_W'(1) : '0;
    end else if (err_det && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    err_pulse_d = err_det;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFill;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule
